// File: rtl/fft_pkg.sv
// Shared radix-5 FFT definitions: Q10 twiddles, the butterfly state enum and
// output saturation.
package fft_pkg;

  localparam int TW_FRAC = 10;

  typedef enum logic [1:0] {LOAD, CALC, EMIT} state_t;

  // Forward W5^m and its conjugate, Q10 (1.0 = 1024), indexed by m = (n*k) mod 5
  localparam logic signed [17:0] W5_RE      [5] = '{18'sd1024, 18'sd316, -18'sd829, -18'sd829, 18'sd316};
  localparam logic signed [17:0] W5_IM      [5] = '{18'sd0, -18'sd974, -18'sd602, 18'sd602, 18'sd974};
  localparam logic signed [17:0] W5_CONJ_RE [5] = '{18'sd1024, 18'sd316, -18'sd829, -18'sd829, 18'sd316};
  localparam logic signed [17:0] W5_CONJ_IM [5] = '{18'sd0, 18'sd974, 18'sd602, -18'sd602, -18'sd974};

  function automatic logic [2:0] tw_idx(input logic [2:0] n, input logic [2:0] k);
    int p;
    p = int'(n) * int'(k);
    return 3'(p % 5);
  endfunction

  // Clamp to the signed range of a w-bit word
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cmul_q10.sv
// Combinational complex multiply, sample x Q10 twiddle, floor-shifted back to
// sample scale and sign-extended to the accumulator width.
module cmul_q10
  import fft_pkg::*;
#(
  parameter int WIDTH     = 15,
  parameter int TW_WIDTH  = 18,
  parameter int ACC_WIDTH = WIDTH + 4
) (
  input  logic signed [WIDTH-1:0]     ar,
  input  logic signed [WIDTH-1:0]     ai,
  input  logic signed [TW_WIDTH-1:0]  br,
  input  logic signed [TW_WIDTH-1:0]  bi,
  output logic signed [ACC_WIDTH-1:0] re,
  output logic signed [ACC_WIDTH-1:0] im
);

  localparam int PW = WIDTH + TW_WIDTH + 1;

  logic signed [PW-1:0] pr, pi;

  always_comb begin
    pr = PW'(ar) * PW'(br) - PW'(ai) * PW'(bi);
    pi = PW'(ar) * PW'(bi) + PW'(ai) * PW'(br);
  end

  assign re = ACC_WIDTH'(pr >>> TW_FRAC);
  assign im = ACC_WIDTH'(pi >>> TW_FRAC);

endmodule

// File: rtl/ifft_butterfly5_serial.sv
// Serial radix-5 inverse DFT butterfly: load 5 samples, accumulate each output
// over 5 cycles through one shared complex multiplier, emit with valid/ready.
module ifft_butterfly5_serial
  import fft_pkg::*;
#(
  parameter int WIDTH     = 15,
  parameter int TW_WIDTH  = 18,
  parameter int ACC_WIDTH = WIDTH + 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_re,
  input  logic signed [WIDTH-1:0] s_im,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_re,
  output logic signed [WIDTH-1:0] m_im,
  output logic [2:0]              m_idx,
  output logic                    busy
);

  state_t state, state_nx;
  logic [2:0] n, k;
  logic signed [WIDTH-1:0]     smp_re [5];
  logic signed [WIDTH-1:0]     smp_im [5];
  logic signed [ACC_WIDTH-1:0] acc_re, acc_im, prod_re, prod_im, acc_nx_re, acc_nx_im;
  logic signed [TW_WIDTH-1:0]  tw_re, tw_im;
  logic [2:0] ti;

  assign ti    = tw_idx(n, k);
  assign tw_re = TW_WIDTH'(W5_CONJ_RE[ti]);
  assign tw_im = TW_WIDTH'(W5_CONJ_IM[ti]);

  cmul_q10 #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_cmul (
    .ar(smp_re[n]), .ai(smp_im[n]), .br(tw_re), .bi(tw_im),
    .re(prod_re), .im(prod_im)
  );

  // n==0 restarts the sum so no separate clear cycle is needed between outputs
  assign acc_nx_re = (n == 3'd0 ? '0 : acc_re) + prod_re;
  assign acc_nx_im = (n == 3'd0 ? '0 : acc_im) + prod_im;

  assign s_ready = (state == LOAD);
  assign m_valid = (state == EMIT);
  assign busy    = (state != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (s_valid && n == 3'd4) state_nx = CALC;
      CALC: if (n == 3'd4)            state_nx = EMIT;
      EMIT: if (m_ready)              state_nx = (k == 3'd4) ? LOAD : CALC;
      default:                        state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n      <= '0;
      k      <= '0;
      acc_re <= '0;
      acc_im <= '0;
      m_re   <= '0;
      m_im   <= '0;
      m_idx  <= '0;
      for (int i = 0; i < 5; i++) begin
        smp_re[i] <= '0;
        smp_im[i] <= '0;
      end
    end else begin
      case (state)
        LOAD: if (s_valid) begin
          smp_re[n] <= s_re;
          smp_im[n] <= s_im;
          if (n == 3'd4) begin
            n <= '0;
            k <= '0;
          end else n <= n + 3'd1;
        end
        CALC: begin
          acc_re <= acc_nx_re;
          acc_im <= acc_nx_im;
          if (n == 3'd4) begin
            m_re  <= WIDTH'(sat(32'(acc_nx_re), WIDTH));
            m_im  <= WIDTH'(sat(32'(acc_nx_im), WIDTH));
            m_idx <= k;
            n     <= '0;
          end else n <= n + 3'd1;
        end
        EMIT: if (m_ready) begin
          k <= (k == 3'd4) ? 3'd0 : k + 3'd1;
          n <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
